// File: rtl/calc_pkg.sv
// calc_pkg: operation and FSM state encodings shared by the calculator datapath.
package calc_pkg;
   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUB   = 2'b01,
      OP_ONESC = 2'b10,
      OP_NEG   = 2'b11
   } op_e;
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;
endpackage

// File: rtl/digit_ripple_adder.sv
// digit_ripple_adder: combinational DIGIT-bit ripple of full adders, exposing the carry into its top bit.
module digit_ripple_adder #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);
   logic [DIGIT:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end
   assign cout     = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/addsub_seq_digit.sv
// addsub_seq_digit: digit-serial adder/subtractor, DIGIT bits per cycle, with start/busy/done handshake
// and carry, signed-overflow and zero flags.
module addsub_seq_digit
   import calc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clr,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf,
   output logic             zero
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, part_q, part_d, sum_q, sum_d;
   logic             carry_q, carry_d, done_q, done_d, co_q, co_d, ovf_q, ovf_d, zero_q, zero_d;
   logic [DIGIT-1:0] ds;
   logic             dco, dcm, accept, last, run;
   logic [WIDTH-1:0] sh;

   digit_ripple_adder #(.DIGIT(DIGIT)) u_dig (
      .x        (x_q[DIGIT-1:0]),
      .y        (y_q[DIGIT-1:0]),
      .cin      (carry_q),
      .s        (ds),
      .cout     (dco),
      .c_msb_in (dcm)
   );

   assign run    = state_q == RUN;
   assign accept = state_q == IDLE && start && !clr;
   assign last   = run && cnt_q == CW'(N - 1);
   // New digit enters at the top; after N shifts the word is aligned.
   assign sh     = WIDTH'({ds, part_q} >> DIGIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = clr ? IDLE : accept ? RUN : last ? IDLE : state_q;
   end

   always_comb begin
      busy = run;
      done = done_q;
      sum  = sum_q;
      co   = co_q;
      ovf  = ovf_q;
      zero = zero_q;
   end

   always_comb begin
      x_d     = accept ? (op[1] ? ~a : a) : run ? x_q >> DIGIT : x_q;
      y_d     = accept ? (op == OP_SUB ? ~b : op == OP_NEG ? '0 : b) : run ? y_q >> DIGIT : y_q;
      carry_d = accept ? (op == OP_SUB || op == OP_NEG || ci) : run ? dco : carry_q;
      cnt_d   = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
      part_d  = accept ? '0 : run ? sh : part_q;
      done_d  = last && !clr;
      sum_d   = done_d ? sh : sum_q;
      co_d    = done_d ? dco : co_q;
      ovf_d   = done_d ? dcm ^ dco : ovf_q;
      zero_d  = done_d ? sh == '0 : zero_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         part_q  <= part_d;
         carry_q <= carry_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end
endmodule

// File: doc/addsub_seq_digit.md
Name: addsub_seq_digit

Overview:
Parametrised, multi-cycle digit-serial adder/subtractor for the calculator datapath. It generalises the fixed 8-bit registered one's-complement adder in three ways: any operand width, a configurable number of bits per cycle, and four operation modes. It adds a start/busy/done handshake plus carry, signed-overflow and zero flags. It sits between the operand registers and the result register of the calculator core, under control of the calculator FSM.

Parameters:
WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT and at least 2.
DIGIT, 2, bits processed per clock cycle; N = WIDTH/DIGIT processing cycles.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  request; sampled only when busy=0.
clr  input  1  synchronous abort; returns to IDLE without done.
op  input  2  operation: 00 ADD, 01 SUB, 10 ONESC, 11 NEG.
a  input  WIDTH  operand A, captured on accepted start.
b  input  WIDTH  operand B, captured on accepted start.
ci  input  1  carry-in for ADD and ONESC; ignored for SUB and NEG.
busy  output  1  high while digits are being processed.
done  output  1  one-cycle pulse when the result is updated.
sum  output  WIDTH  result register, held until the next completion.
co  output  1  carry-out of the MSB.
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
zero  output  1  sum == 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, busy=0, done=0, sum=0, co=0, ovf=0, zero=0, digit counter=0, carry register=0.
- Operand preprocessing at capture:
  - ADD: X=a, Y=b, c0=ci.
  - SUB: X=a, Y=~b, c0=1. co=1 means no borrow.
  - ONESC: X=~a, Y=b, c0=ci (legacy calculator mode).
  - NEG: X=~a, Y=0, c0=1.
- States:
  - IDLE: start=1 and clr=0 at edge E0 captures X, Y and c0, clears the counter, sets busy=1, goes to RUN.
  - RUN: edges E1..EN each add digit i (bits i*DIGIT+DIGIT-1 : i*DIGIT) of X and Y with the carry register. The digit sum goes into a shift/partial-result register, the carry-out into the carry register, and the counter increments.
  - At EN (counter = N-1): sum, co, ovf and zero are all updated from the completed word. done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: done is high in the cycle after edge EN, i.e. N cycles after the start edge. Throughput is one operation per N cycles; start may be asserted in the same cycle done is high, and is accepted.
- start while busy=1 is ignored and not queued. Changes to a, b, op or ci during RUN have no effect.
- clr=1 has priority over start and over RUN. Next state is IDLE, busy=0, done=0. sum and flags keep their previous values; the partial result is discarded.
- Reset mid-operation: immediate return to reset values; no done.
- ovf needs the carry into bit WIDTH-1. It is taken from inside the final digit's ripple chain (chain bit DIGIT-1 carry-in).
- DIGIT=WIDTH is legal: N=1, latency 1 cycle.
- No sign gating on inputs: every accepted start produces a result.

Decomposition:
- Shared package (calc_pkg): op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_ONESC=2'b10, OP_NEG=2'b11; FSM state encodings IDLE and RUN.
- One sub-module: digit_ripple_adder, a combinational DIGIT-bit ripple of full adders. Inputs: x, y, cin. Outputs: s, cout, and c_msb_in (carry into its top bit). The control FSM, counter and shift registers stay in addsub_seq_digit.

Test Plan:
All scenarios use WIDTH=8, DIGIT=2 (N=4).
- ADD a=100, b=27, ci=0 -> after 4 cycles done=1 for one cycle; sum=127, co=0, ovf=0, zero=0; busy high for exactly 4 cycles.
- ADD a=0x7F, b=0x01, ci=0 -> sum=0x80, ovf=1, co=0. SUB a=5, b=7 -> sum=0xFE, co=0, ovf=0. SUB a=9, b=9 -> sum=0, zero=1, co=1.
- ONESC a=0x0F, b=0x10, ci=1 -> sum=0x01, co=1. NEG a=0x80 -> sum=0x80, ovf=1. NEG a=0x00 -> sum=0, co=1, zero=1.
- Back-to-back: second start asserted in the done cycle is accepted and completes 4 cycles later. A start pulsed mid-RUN with other operands is ignored: one done only, and the result matches the first operands.
- clr asserted at E2 of an ADD -> busy drops next cycle, no done pulse, sum keeps its prior value. rst_n pulled low mid-RUN -> all outputs 0 immediately, asynchronously.
- Sweep DIGIT in {1, 2, 4, 8} with random a, b, op, ci against a reference model -> sum, co and ovf match, and latency equals WIDTH/DIGIT.
